// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU. Single-cycle ops return a result the next
// clock; MUL/MULHU/DIVU/REMU iterate one bit per clock for WIDTH clocks.
//
// state | meaning
// IDLE  | no result held, ready for a new op
// BUSY  | iterative multiply/divide in progress, counter counts steps down
// DONE  | result valid on out_s, waiting for the consumer to take it
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_zero,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;

    logic               accept;
    logic               new_iter, new_div;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_err;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic               step_div, step_hi;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   step_res;

    assign in_ready  = rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign out_s     = res_q;
    assign out_zero  = zero_q;
    assign out_err   = err_q;

    assign new_iter = (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    assign new_div  = (op == OP_DIVU) || (op == OP_REMU);

    // Single-cycle datapath, evaluated on the incoming operands.
    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (op)
            OP_ADD:  sc_res = in_a + in_b;
            OP_SUB:  sc_res = in_a - in_b;
            OP_AND:  sc_res = in_a & in_b;
            OP_OR:   sc_res = in_a | in_b;
            OP_XOR:  sc_res = in_a ^ in_b;
            OP_SLL:  sc_res = in_a << in_b[SHW-1:0];
            OP_SRL:  sc_res = in_a >> in_b[SHW-1:0];
            OP_SRA:  sc_res = WIDTH'($signed(in_a) >>> in_b[SHW-1:0]);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            default: sc_err = !new_iter;
        endcase
    end

    // One iteration step: shift-add multiply on {hi, multiplier}, restoring
    // divide on {remainder, dividend}. The quotient bit shifts in at the LSB,
    // so a zero divisor naturally yields all-ones quotient and remainder in_a.
    always_comb begin
        step_div = (op_q == OP_DIVU) || (op_q == OP_REMU);
        step_hi  = (op_q == OP_MULHU) || (op_q == OP_REMU);
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_rem  = div_ge ? (div_sh[WIDTH-1:0] - opnd_q) : div_sh[WIDTH-1:0];
        if (step_div)
            step_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
        else
            step_next = {mul_sum, acc_q[WIDTH-1:1]};
        step_res = step_hi ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            S_BUSY: begin
                acc_d = step_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d = S_DONE;
                    res_d   = step_res;
                    zero_d  = (step_res == '0);
                    err_d   = 1'b0;
                end
            end
            default: begin
                if (state_q == S_DONE && out_ready)
                    state_d = S_IDLE;
                if (accept) begin
                    op_d = op;
                    if (new_iter) begin
                        state_d = S_BUSY;
                        cnt_d   = (SHW+1)'(WIDTH);
                        opnd_d  = new_div ? in_b : in_a;
                        acc_d   = {{WIDTH{1'b0}}, (new_div ? in_a : in_b)};
                    end else begin
                        state_d = S_DONE;
                        res_d   = sc_res;
                        zero_d  = (sc_res == '0);
                        err_d   = sc_err;
                    end
                end
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle integer ALU in the execute stage. It adds SLT/SLTU and iterative unsigned multiply and divide, and a result zero flag. It takes operands through a valid/ready handshake and returns a registered result through a second valid/ready handshake. Single-cycle ops sustain one result per clock; MUL/MULHU/DIVU/REMU take WIDTH extra cycles.

## Interface
- WIDTH, 32: operand/result width, ≥ 8, power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from in_b (derived, not overridden).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- op  in  4  operation code, sampled on accept.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept; accept = in_valid & in_ready.
- out_s  out  WIDTH  result, registered.
- out_zero  out  1  out_s == 0.
- out_err  out  1  illegal op code.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result; retire = out_valid & out_ready.

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU, 14–15 illegal.
- Shifts use in_b[SHW-1:0] only. SRA is arithmetic on in_a.
- ADD/SUB wrap modulo 2^WIDTH.
- Illegal op: result 0, out_zero 1, out_err 1, single-cycle latency.
- MUL/MULHU: shift-add, one multiplier bit per cycle, 2·WIDTH accumulator.
- DIVU/REMU: restoring division, one quotient bit per cycle.
- Divide by zero: DIVU → all ones, REMU → in_a. Same latency as a normal divide; out_err 0.
- FSM states and transitions:
  - IDLE: on accept of a single-cycle op → DONE; on accept of an iterative op → BUSY with counter = WIDTH.
  - BUSY: perform one step and decrement the counter each cycle; on the last step → DONE.
  - DONE: out_valid = 1. On retire, if a new accept happens in the same cycle, go to DONE or BUSY according to the new op; otherwise go to IDLE.
- in_ready = rst & (state==IDLE | (state==DONE & out_ready)). It is combinational and low during BUSY.
- Operands and op are captured on accept. Later changes on the inputs do not affect the operation in flight.
- out_s, out_zero and out_err stay stable while out_valid=1 and out_ready=0.
- Reset, including mid-BUSY or in DONE: state IDLE, counter 0, out_s 0, out_zero 0, out_err 0, out_valid 0. The operation in flight is discarded and no result is produced.

## Timing
- Reset values: out_s 0, out_zero 0, out_err 0, out_valid 0. in_ready is 0 while rst=0 and 1 in the first cycle after release.
- Single-cycle op accepted in cycle N: out_valid=1 in cycle N+1.
- Iterative op accepted in cycle N: BUSY in cycles N+1..N+WIDTH, out_valid=1 in cycle N+WIDTH+1 (N+33 at WIDTH=32).
- Back-to-back single-cycle ops with out_ready held 1: one accept and one retire every cycle, no bubbles.
- Backpressure: with out_ready=0 in DONE, in_ready=0 and no new op is accepted. The result holds indefinitely.
- Retire and accept in the same cycle are legal. The new result replaces the old one on the next edge.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 accepted in cycle N → out_s=0x80000000, out_valid in N+1. SUB 5−5 → out_s=0, out_zero=1.
- SRA in_a=0x80000000, in_b=0x00000024 → shift amount 4, out_s=0xF8000000. SRL of the same operands → 0x08000000.
- SLT in_a=0xFFFFFFFF, in_b=1 → 1. SLTU on the same operands → 0. op=15 → out_s=0, out_err=1.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → out_s=0x00000001. MULHU on the same operands → 0xFFFFFFFE. out_valid exactly at N+33; in_ready=0 throughout BUSY.
- DIVU 100/7 → 14 and REMU 100/7 → 2. DIVU 9/0 → 0xFFFFFFFF and REMU 9/0 → 9.
- Hold out_ready=0 for 5 cycles after a result → out_s stable and no accept. Assert rst=0 at cycle N+10 of a DIVU → next cycle out_valid=0 and out_s=0; a following ADD 1+2 returns 3 with normal latency.
